// File: rtl/enc_pkg.sv
// Shared MIPS encoding constants, op enum and field-packing helpers for the instruction encoder.
// ENC_DELAY_SLOT_PAD_EN adds the PAD state that writes a NOP after every branch/jump.
package enc_pkg;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_ADD     = 4'd1,
    OP_SUB     = 4'd2,
    OP_AND     = 4'd3,
    OP_OR      = 4'd4,
    OP_SLT     = 4'd5,
    OP_LW      = 4'd6,
    OP_SW      = 4'd7,
    OP_BEQ     = 4'd8,
    OP_BNE     = 4'd9,
    OP_ADDI    = 4'd10,
    OP_ANDI    = 4'd11,
    OP_ORI     = 4'd12,
    OP_SLTI    = 4'd13,
    OP_J       = 4'd14,
    OP_ILLEGAL = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WORD
`ifdef ENC_DELAY_SLOT_PAD_EN
    , ST_PAD
`endif
  } state_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, 5'h00, funct};
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  // Ops whose word is followed by a delay slot when padding is enabled.
  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J);
  endfunction

endpackage

// File: rtl/instr_format.sv
// Purely combinational packer: symbolic op and fields to a 32-bit MIPS word.
// Op 15 yields NOP_WORD with illegal raised; fields a format does not use are ignored.
module instr_format
  import enc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    word    = NOP_WORD;
    illegal = 1'b0;
    case (op_e'(op))
      OP_NOP:     word = NOP_WORD;
      OP_ADD:     word = pack_r(rs, rt, rd, FUNCT_ADD);
      OP_SUB:     word = pack_r(rs, rt, rd, FUNCT_SUB);
      OP_AND:     word = pack_r(rs, rt, rd, FUNCT_AND);
      OP_OR:      word = pack_r(rs, rt, rd, FUNCT_OR);
      OP_SLT:     word = pack_r(rs, rt, rd, FUNCT_SLT);
      OP_LW:      word = pack_i(OPC_LW,   rs, rt, imm);
      OP_SW:      word = pack_i(OPC_SW,   rs, rt, imm);
      OP_BEQ:     word = pack_i(OPC_BEQ,  rs, rt, imm);
      OP_BNE:     word = pack_i(OPC_BNE,  rs, rt, imm);
      OP_ADDI:    word = pack_i(OPC_ADDI, rs, rt, imm);
      OP_ANDI:    word = pack_i(OPC_ANDI, rs, rt, imm);
      OP_ORI:     word = pack_i(OPC_ORI,  rs, rt, imm);
      OP_SLTI:    word = pack_i(OPC_SLTI, rs, rt, imm);
      OP_J:       word = {OPC_J, target};
      OP_ILLEGAL: illegal = 1'b1;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential MIPS encoder/loader: valid/ready request in, one encoded word per
// memory write at consecutive addresses. ENC_DELAY_SLOT_PAD_EN enables NOP delay-slot padding.
module instr_encoder
  import enc_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err_illegal,
  output logic              err_wrap
);

  state_e            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata, wdata_nx;
  logic [31:0]       fmt_word;
  logic              fmt_illegal;
  logic              pad_due;
  logic              accept, hs, take;

  instr_format u_format (
    .op      (in_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .target  (in_target),
    .word    (fmt_word),
    .illegal (fmt_illegal)
  );

  assign imem_we    = (state != ST_IDLE);
  assign imem_addr  = addr;
  assign imem_wdata = wdata;
  assign accept     = imem_we && imem_ready;
  assign in_ready   = (state == ST_IDLE) || ((state == ST_WORD) && imem_ready && !pad_due);
  assign hs         = in_valid && in_ready;
  assign take       = hs && !fmt_illegal;

  always_comb begin
    state_nx = state;
    wdata_nx = wdata;
    case (state)
      ST_IDLE: begin
        if (take) begin
          state_nx = ST_WORD;
          wdata_nx = fmt_word;
        end
      end
      ST_WORD: begin
        if (accept) begin
`ifdef ENC_DELAY_SLOT_PAD_EN
          if (pad_due) begin
            state_nx = ST_PAD;
            wdata_nx = NOP_WORD;
          end else
`endif
          if (take) begin
            state_nx = ST_WORD;
            wdata_nx = fmt_word;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
`ifdef ENC_DELAY_SLOT_PAD_EN
      ST_PAD: begin
        if (accept) state_nx = ST_IDLE;
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr        <= ADDR_W'(BASE_ADDR);
      wdata       <= NOP_WORD;
      err_illegal <= 1'b0;
      err_wrap    <= 1'b0;
    end else begin
      state <= state_nx;
      wdata <= wdata_nx;
      if (accept) begin
        addr <= addr + ADDR_W'(1);
        if (&addr) err_wrap <= 1'b1;
      end
      if (hs && fmt_illegal) err_illegal <= 1'b1;
    end
  end

`ifdef ENC_DELAY_SLOT_PAD_EN
  // Remembers that the held word is a branch/jump and must be followed by a NOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      pad_due <= 1'b0;
    end else if (take) begin
      pad_due <= is_branch(in_op);
    end else if (accept) begin
      pad_due <= 1'b0;
    end
  end
`else
  assign pad_due = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized traffic scored
// against a queue-based reference of expected memory writes.
module tb_instr_encoder;

  localparam int ADDR_W = 10;
  localparam int BASE   = 0;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_op = '0;
  logic [4:0]        in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0]       in_imm = '0;
  logic [25:0]       in_target = '0;
  logic              imem_we;
  logic              imem_ready = 1'b1;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              err_illegal, err_wrap;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_imm      (in_imm),
    .in_target   (in_target),
    .imem_we     (imem_we),
    .imem_ready  (imem_ready),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .err_illegal (err_illegal),
    .err_wrap    (err_wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
  endtask

  // Reference model: pending writes in order, expected next address, sticky flags.
  typedef struct {
    logic [31:0] word;
    bit          is_pad;
  } exp_t;

  exp_t q[$];
  int   exp_addr = BASE;
  bit   m_ill = 0, m_wrap = 0;
  bit   hs_seen = 0;
  bit   rand_ready = 0;

  int unsigned funct_tab[16] = '{0, 'h20, 'h22, 'h24, 'h25, 'h2A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int unsigned opc_tab[16]   = '{0, 0, 0, 0, 0, 0, 'h23, 'h2B, 'h04, 'h05, 'h08, 'h0C, 'h0D, 'h0A, 'h02, 0};

  function automatic logic [31:0] ref_word(int unsigned op, int unsigned rs, int unsigned rt,
                                           int unsigned rd, int unsigned imm, int unsigned tgt);
    int unsigned w;
    if (op == 0) w = 0;
    else if (op <= 5) w = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + funct_tab[op];
    else if (op <= 13) w = opc_tab[op] * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
    else w = opc_tab[op] * (1 << 26) + tgt;
    return w;
  endfunction

  function automatic bit pad_after(int unsigned op);
`ifdef ENC_DELAY_SLOT_PAD_EN
    return (op == 8) || (op == 9) || (op == 14);
`else
    return 0;
`endif
  endfunction

  // One clock: score outputs at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    bit we_exp, rdy_exp;
    exp_t e;
    hs_seen = 0;
    @(negedge clk);
    if (reset) begin
      q.delete();
      exp_addr = BASE;
      m_ill = 0;
      m_wrap = 0;
    end else begin
      we_exp  = (q.size() != 0);
      rdy_exp = (q.size() == 0) || (q.size() == 1 && imem_ready && !q[0].is_pad);
      check("imem_we", imem_we, we_exp);
      check("in_ready", in_ready, rdy_exp);
      check("err_illegal", err_illegal, m_ill);
      check("err_wrap", err_wrap, m_wrap);
      if (we_exp && imem_ready) begin
        e = q.pop_front();
        check("wr_addr", imem_addr, exp_addr);
        check("wr_data", imem_wdata, e.word);
        if (exp_addr == DEPTH - 1) begin
          exp_addr = 0;
          m_wrap = 1;
        end else begin
          exp_addr++;
        end
      end
      if (in_valid && rdy_exp) begin
        hs_seen = 1;
        if (in_op == 4'd15) begin
          m_ill = 1;
        end else begin
          q.push_back('{ref_word(in_op, in_rs, in_rt, in_rd, in_imm, in_target), 1'b0});
          if (pad_after(in_op)) q.push_back('{32'h0, 1'b1});
        end
      end
    end
    @(posedge clk);
    #1;
    if (rand_ready) imem_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    int budget;
    in_valid = 1'b1;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
    budget = 0;
    do begin
      tick();
      budget++;
    end while (!hs_seen && budget < 50);
    if (!hs_seen) check("hs_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_imem_we", imem_we, 1'b0);
    check("rst_addr", imem_addr, BASE);
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_errs", {err_illegal, err_wrap}, 2'b00);

    // ADD, then LW and J streamed back-to-back.
    imem_ready = 1'b1;
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    check("add_word", imem_wdata, 32'h00221820);
    check("add_addr", imem_addr, 0);
    send(4'd6, 5'd4, 5'd5, 5'd0, 16'hFFFC, 26'h0);
    check("lw_word", imem_wdata, 32'h8C85FFFC);
    check("lw_addr", imem_addr, 1);
    send(4'd14, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
    check("j_word", imem_wdata, 32'h08000010);
    check("j_addr", imem_addr, 2);
    idle(4);

    // Three-cycle stall on a held word.
    imem_ready = 1'b0;
    send(4'd2, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0);
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_wdata", imem_wdata, 32'h00E84822);
      check("stall_addr", imem_addr, exp_addr);
      tick();
    end
    imem_ready = 1'b1;
    idle(2);

    // Illegal op: no write, sticky flag, next word at the unadvanced address.
    send(4'd15, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    tick();
    check("ill_flag", err_illegal, 1'b1);
    check("ill_no_write", imem_we, 1'b0);
    send(4'd10, 5'd3, 5'd6, 5'd0, 16'h0042, 26'h0);
    check("post_ill_addr", imem_addr, exp_addr);
    idle(2);

`ifdef ENC_DELAY_SLOT_PAD_EN
    send(4'd8, 5'd1, 5'd2, 5'd0, 16'h0003, 26'h0);
    check("beq_word", imem_wdata, 32'h10220003);
    check("beq_hold_ready", in_ready, 1'b0);
    tick();
    check("pad_word", imem_wdata, 32'h0);
    check("pad_ready", in_ready, 1'b0);
    idle(2);
`endif

    // Reset in the middle of a stalled write.
    imem_ready = 1'b0;
    send(4'd9, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    imem_ready = 1'b1;
    check("midrst_we", imem_we, 1'b0);
    check("midrst_addr", imem_addr, BASE);
    check("midrst_wdata", imem_wdata, 32'h0);
    check("midrst_errs", {err_illegal, err_wrap}, 2'b00);

    // Random traffic, long enough to wrap the address space.
    rand_ready = 1;
    for (int i = 0; i < 1400; i++) begin
      if ($urandom_range(0, 7) == 0) tick();
      send(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
           16'($urandom), 26'($urandom));
    end
    rand_ready = 0;
    imem_ready = 1'b1;
    idle(4);
    check("final_wrap", err_wrap, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
